// File: rtl/spi_ram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : spi_ram_ctrl
//  Description : Arbitrates the CPU fetch and load/store ports onto an
//                external SPI RAM. Each grant runs one 40-bit mode-0 frame
//                (command, 16-bit address, 16-bit data word, big-endian).
//                Optional macro SPI_RAM_SEQ_INIT_EN: after reset, send the
//                16-bit mode-register write 0x01 0x40 before serving requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_ctrl #(
    parameter int CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [15:0] fetch_addr,
    output logic        fetch_ready,
    output logic [15:0] fetch_data,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    output logic        data_ready,
    output logic [15:0] data_rdata,
    output logic        spi_select,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy
);

    localparam logic [1:0]  c_st_idle  = 2'd1;
    localparam logic [1:0]  c_st_shift = 2'd2;
    localparam logic [1:0]  c_st_done  = 2'd3;
`ifdef SPI_RAM_SEQ_INIT_EN
    localparam logic [1:0]  c_st_init  = 2'd0;
    localparam logic [1:0]  c_st_reset = c_st_init;
    // Mode-register write, left-aligned so it leaves MSB first like any frame.
    localparam logic [39:0] c_init_frame = {8'h01, 8'h40, 24'h000000};
`else
    localparam logic [1:0]  c_st_reset = c_st_idle;
`endif
    localparam logic [15:0] c_div_last = 16'(CLK_DIV - 1);

    logic [1:0]  r_state;
    logic [15:0] r_div_cnt;
    logic [5:0]  r_bit_cnt;
    logic [38:0] r_shift;      // frame bits still to send; bit 39 sits in r_mosi
    logic [15:0] r_rd;
    logic        r_port_data;
    logic        r_init;
    logic        r_select;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_fetch_ready;
    logic        r_data_ready;
    logic [15:0] r_fetch_data;
    logic [15:0] r_data_rdata;

    logic        w_grant;
    logic        w_grant_data;
    logic [39:0] w_frame;

    // Fixed-priority arbitration and frame assembly for the requester that wins.
    always_comb begin
        w_grant      = data_req | fetch_req;
        w_grant_data = data_req;
        if (data_req) begin
            w_frame = {(data_we ? 8'h02 : 8'h03), data_addr, (data_we ? data_wdata : 16'h0000)};
        end else begin
            w_frame = {8'h03, fetch_addr, 16'h0000};
        end
    end

    // Sequencer: grant, serialise the frame in mode 0, then pulse ready in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_reset;
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_rd          <= '0;
            r_port_data   <= 1'b0;
            r_init        <= 1'b0;
            r_select      <= 1'b1;
            r_sclk        <= 1'b0;
            r_mosi        <= 1'b0;
            r_fetch_ready <= 1'b0;
            r_data_ready  <= 1'b0;
            r_fetch_data  <= '0;
            r_data_rdata  <= '0;
        end else begin
            r_fetch_ready <= 1'b0;
            r_data_ready  <= 1'b0;
            case (r_state)
`ifdef SPI_RAM_SEQ_INIT_EN
                c_st_init: begin
                    r_mosi    <= c_init_frame[39];
                    r_shift   <= c_init_frame[38:0];
                    r_bit_cnt <= 6'd15;
                    r_div_cnt <= '0;
                    r_sclk    <= 1'b0;
                    r_select  <= 1'b0;
                    r_init    <= 1'b1;
                    r_state   <= c_st_shift;
                end
`endif
                c_st_idle: begin
                    if (w_grant) begin
                        r_mosi      <= w_frame[39];
                        r_shift     <= w_frame[38:0];
                        r_bit_cnt   <= 6'd39;
                        r_div_cnt   <= '0;
                        r_sclk      <= 1'b0;
                        r_select    <= 1'b0;
                        r_port_data <= w_grant_data;
                        r_init      <= 1'b0;
                        r_state     <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    if (r_div_cnt == c_div_last) begin
                        r_div_cnt <= '0;
                        if (!r_sclk) begin
                            // Rising spi_clk: the RAM's bit is stable now.
                            r_sclk <= 1'b1;
                            r_rd   <= {r_rd[14:0], spi_miso};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit_cnt == 6'd0) begin
                                r_select <= 1'b1;
                                r_mosi   <= 1'b0;
                                r_state  <= c_st_done;
                                if (!r_init) begin
                                    if (r_port_data) begin
                                        r_data_ready <= 1'b1;
                                        r_data_rdata <= r_rd;
                                    end else begin
                                        r_fetch_ready <= 1'b1;
                                        r_fetch_data  <= r_rd;
                                    end
                                end
                            end else begin
                                // Falling spi_clk: present the next bit.
                                r_bit_cnt <= r_bit_cnt - 6'd1;
                                r_mosi    <= r_shift[38];
                                r_shift   <= {r_shift[37:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 16'd1;
                    end
                end
                c_st_done: begin
                    r_init  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign fetch_ready = r_fetch_ready;
    assign fetch_data  = r_fetch_data;
    assign data_ready  = r_data_ready;
    assign data_rdata  = r_data_rdata;
    assign spi_select  = r_select;
    assign spi_clk     = r_sclk;
    assign spi_mosi    = r_mosi;
    assign busy        = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_spi_ram_ctrl
//  Description : Scoreboard bench for spi_ram_ctrl with a behavioural SPI RAM.
//                Honours SPI_RAM_SEQ_INIT_EN when the design is built with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fetch_req, data_req, data_we;
    logic [15:0] fetch_addr, data_addr, data_wdata;
    logic        fetch_ready, data_ready;
    logic [15:0] fetch_data, data_rdata;
    logic        spi_select, spi_clk, spi_mosi, spi_miso;
    logic        busy;

    logic        fetch_req3;
    logic [15:0] fetch_addr3;
    logic        data_req3, data_we3;
    logic [15:0] data_addr3, data_wdata3;
    logic        fetch_ready3, data_ready3;
    logic [15:0] fetch_data3, data_rdata3;
    logic        spi_select3, spi_clk3, spi_mosi3;
    logic        spi_miso3;
    logic        busy3;

    spi_ram_ctrl #(.CLK_DIV(1)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_data(fetch_data),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ready(data_ready), .data_rdata(data_rdata),
        .spi_select(spi_select), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .busy(busy)
    );

    spi_ram_ctrl #(.CLK_DIV(3)) dut3 (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req3), .fetch_addr(fetch_addr3),
        .fetch_ready(fetch_ready3), .fetch_data(fetch_data3),
        .data_req(data_req3), .data_we(data_we3), .data_addr(data_addr3),
        .data_wdata(data_wdata3), .data_ready(data_ready3), .data_rdata(data_rdata3),
        .spi_select(spi_select3), .spi_clk(spi_clk3), .spi_mosi(spi_mosi3),
        .spi_miso(spi_miso3), .busy(busy3)
    );

    typedef struct {
        int          port;      // 0 fetch, 1 data, 2 fetch on the CLK_DIV=3 instance
        logic [15:0] data;
        bit          chk_data;
        int          cyc;
    } exp_t;

    typedef struct {
        int          nbits;
        logic [39:0] val;
    } frm_t;

    exp_t sbq[$];
    frm_t fq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

`ifdef SPI_RAM_SEQ_INIT_EN
    bit exp_busy_rst = 1'b1;
`else
    bit exp_busy_rst = 1'b0;
`endif

    logic [7:0] mem [0:65535];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int port, input logic [15:0] d, input bit cd, input int c);
        exp_t e;
        e.port = port; e.data = d; e.chk_data = cd; e.cyc = c;
        sbq.push_back(e);
    endtask

    task automatic push_frm(input int n, input logic [39:0] v);
        frm_t f;
        f.nbits = n; f.val = v;
        fq.push_back(f);
    endtask

    // ---------------- SPI RAM model and MOSI frame checker -----------------
    int          m_cnt;
    logic [39:0] m_rx;
    bit          m_act = 1'b0;
    bit          m_prev;
    logic [7:0]  m_cmd;
    logic [15:0] m_addr, m_rword;
    bit          skip_frame = 1'b0;

    initial begin
        spi_miso = 1'b0;
        forever begin
            frm_t f;
            @(negedge clk);
            if (!spi_select) begin
                if (!m_act) begin
                    m_act = 1'b1; m_cnt = 0; m_rx = '0; m_prev = 1'b0; m_cmd = 8'h00;
                end
                if (spi_clk && !m_prev) begin
                    m_rx = {m_rx[38:0], spi_mosi};
                    m_cnt++;
                    if (m_cnt == 24) begin
                        m_cmd   = m_rx[23:16];
                        m_addr  = m_rx[15:0];
                        m_rword = {mem[m_addr], mem[m_addr + 16'd1]};
                    end
                end
                m_prev = spi_clk;
                if (m_cnt >= 24 && m_cnt < 40 && m_cmd == 8'h03)
                    spi_miso = m_rword[15 - (m_cnt - 24)];
                else
                    spi_miso = 1'b0;
            end else if (m_act) begin
                m_act = 1'b0;
                spi_miso = 1'b0;
                if (m_cnt == 40 && m_rx[39:32] == 8'h02) begin
                    mem[m_rx[31:16]]          = m_rx[15:8];
                    mem[m_rx[31:16] + 16'd1]  = m_rx[7:0];
                end
                if (skip_frame) begin
                    skip_frame = 1'b0;
                end else if (fq.size() == 0) begin
                    chk("frame_unexpected_bits", m_cnt, 0);
                end else begin
                    f = fq.pop_front();
                    chk("frame_bits", m_cnt, f.nbits);
                    chk("frame_mosi", m_rx, f.val);
                end
            end
        end
    end

    // ---------------- spi_clk phase-length monitor for CLK_DIV=3 -----------
    bit watch3 = 1'b0;
    bit r3_act = 1'b0;
    bit r3_prev;
    int r3_run, r3_runs = 0, r3_bad = 0;

    initial forever begin
        @(negedge clk);
        if (!spi_select3 && watch3) begin
            if (!r3_act) begin
                r3_act = 1'b1; r3_run = 1; r3_runs = 0; r3_bad = 0; r3_prev = spi_clk3;
                if (spi_clk3 != 1'b0) r3_bad++;
            end else if (spi_clk3 == r3_prev) begin
                r3_run++;
            end else begin
                r3_runs++;
                if (r3_run != 3) r3_bad++;
                r3_run = 1; r3_prev = spi_clk3;
            end
        end else if (r3_act) begin
            r3_act = 1'b0;
            r3_runs++;
            if (r3_run != 3) r3_bad++;
        end
    end

    // ---------------- ready monitor: pops the scoreboard -------------------
    task automatic check_ready(input int port, input logic [15:0] d);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("ready_unexpected_port", port, 99);
        end else begin
            e = sbq.pop_front();
            chk("ready_port", port, e.port);
            if (e.chk_data) chk("ready_data", d, e.data);
            chk("ready_cycle", cyc, e.cyc);
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (fetch_ready)  check_ready(0, fetch_data);
        if (data_ready)   check_ready(1, data_rdata);
        if (fetch_ready3) check_ready(2, fetch_data3);
    end

    // ---------------- requester / helpers ----------------------------------
    task automatic do_req(input int port, input bit we, input logic [15:0] addr,
                          input logic [15:0] wd, input bit scr);
        bit got = 1'b0;
        case (port)
            0:       begin fetch_addr = addr; fetch_req = 1'b1; end
            1:       begin data_we = we; data_addr = addr; data_wdata = wd; data_req = 1'b1; end
            default: begin fetch_addr3 = addr; fetch_req3 = 1'b1; end
        endcase
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (i == 0 && scr) begin
                // The grant edge has passed; the block must not look at these again.
                case (port)
                    0:       fetch_addr = ~addr;
                    1:       begin data_addr = ~addr; data_wdata = ~wd; data_we = ~we; end
                    default: fetch_addr3 = ~addr;
                endcase
            end
            if ((port == 0 && fetch_ready) || (port == 1 && data_ready) ||
                (port == 2 && fetch_ready3)) begin
                got = 1'b1;
                break;
            end
        end
        case (port)
            0:       fetch_req = 1'b0;
            1:       data_req = 1'b0;
            default: fetch_req3 = 1'b0;
        endcase
        chk("req_completed", got, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("idle_reached", ok, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ------------------------------------
    initial begin
        int k;
        rst = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        fetch_req3 = 1'b0; fetch_addr3 = '0;
        data_req3 = 1'b0; data_we3 = 1'b0; data_addr3 = '0; data_wdata3 = '0;
        spi_miso3 = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hBE; mem[16'h1235] = 8'hEF;
        mem[16'h0010] = 8'hC3; mem[16'h0011] = 8'h3C; mem[16'h0012] = 8'h77;
`ifdef SPI_RAM_SEQ_INIT_EN
        fetch_req  = 1'b1;
        fetch_addr = 16'h1234;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_select", spi_select, 1);
        chk("rst_sclk", spi_clk, 0);
        chk("rst_mosi", spi_mosi, 0);
        chk("rst_busy", busy, exp_busy_rst);
        chk("rst_fetch_ready", fetch_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_fetch_data", fetch_data, 0);
        chk("rst_data_rdata", data_rdata, 0);
        rst = 1'b0;
        k = cyc;

        // Fetch read of 0x1234
`ifdef SPI_RAM_SEQ_INIT_EN
        push_frm(16, 40'h00_0000_0140);
        push_frm(40, 40'h03_1234_0000);
        push_exp(0, 16'hBEEF, 1'b1, k + 115);
        do_req(0, 1'b0, 16'h1234, 16'h0000, 1'b0);
`else
        push_frm(40, 40'h03_1234_0000);
        push_exp(0, 16'hBEEF, 1'b1, k + 81);
        do_req(0, 1'b0, 16'h1234, 16'h0000, 1'b1);
`endif
        wait_idle();

        // Store 0xA55A to 0x00FE
        k = cyc;
        push_frm(40, 40'h02_00FE_A55A);
        push_exp(1, 16'h0000, 1'b0, k + 81);
        do_req(1, 1'b1, 16'h00FE, 16'hA55A, 1'b1);
        wait_idle();
        chk("mem_00fe", mem[16'h00FE], 8'hA5);
        chk("mem_00ff", mem[16'h00FF], 8'h5A);

        // Load back from 0x00FE
        k = cyc;
        push_frm(40, 40'h03_00FE_0000);
        push_exp(1, 16'hA55A, 1'b1, k + 81);
        do_req(1, 1'b0, 16'h00FE, 16'h0000, 1'b1);
        wait_idle();

        // Simultaneous requests: data first, fetch granted in the IDLE after DONE
        k = cyc;
        push_frm(40, 40'h03_0010_0000);
        push_frm(40, 40'h03_1234_0000);
        push_exp(1, 16'hC33C, 1'b1, k + 81);
        push_exp(0, 16'hBEEF, 1'b1, k + 163);
        fork
            do_req(1, 1'b0, 16'h0010, 16'h0000, 1'b0);
            do_req(0, 1'b0, 16'h1234, 16'h0000, 1'b0);
        join
        wait_idle();

        // Reset in cycle 30 of a read: frame aborted, no ready
        fetch_addr = 16'h1234;
        fetch_req  = 1'b1;
        skip_frame = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        fetch_req = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_select", spi_select, 1);
        chk("abort_sclk", spi_clk, 0);
        chk("abort_busy", busy, exp_busy_rst);
        chk("abort_fetch_ready", fetch_ready, 0);
        rst = 1'b0;
`ifdef SPI_RAM_SEQ_INIT_EN
        push_frm(16, 40'h00_0000_0140);
`endif
        repeat (100) @(posedge clk);
        #1;
        wait_idle();

        // Odd (unaligned) fetch address after recovery
        k = cyc;
        push_frm(40, 40'h03_0011_0000);
        push_exp(0, 16'h3C77, 1'b1, k + 81);
        do_req(0, 1'b0, 16'h0011, 16'h0000, 1'b1);
        wait_idle();

        // CLK_DIV = 3 instance: 3/3 spi_clk phases and ready at 241
        watch3 = 1'b1;
        k = cyc;
        push_exp(2, 16'hFFFF, 1'b1, k + 241);
        do_req(2, 1'b0, 16'h4321, 16'h0000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("div3_phase_count", r3_runs, 80);
        chk("div3_bad_phases", r3_bad, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", sbq.size(), 0);
        chk("frames_drained", fq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
